// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator with registered offset-binary amplitude scaling.
// Optional build macro ADSR_EXP_RELEASE_EN selects an exponential release tail instead of linear.
`timescale 1ns/1ps

module adsr_envelope #(
    parameter int BITDEPTH  = 12,
    parameter int ENVBITS   = 16,
    parameter int RATEBITS  = 8,
    parameter int STEPSHIFT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clock,
    input  logic                gate,
    input  logic [RATEBITS-1:0] attack_rate,
    input  logic [RATEBITS-1:0] decay_rate,
    input  logic [7:0]          sustain_level,
    input  logic [RATEBITS-1:0] release_rate,
    input  logic [BITDEPTH-1:0] sample_in,
    output logic [BITDEPTH-1:0] sample_out,
    output logic [ENVBITS-1:0]  env_level,
    output logic [2:0]          env_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // One guard bit above the envelope width keeps every add/subtract free of wrap-around.
    localparam int GW = ENVBITS + 1;
    localparam logic [GW-1:0] FULL_SCALE = {1'b0, {ENVBITS{1'b1}}};
    localparam logic [BITDEPTH-1:0] MIDPOINT = {1'b1, {(BITDEPTH-1){1'b0}}};

    logic sync1_q, sync2_q, sync3_q;
    logic tick_d, tick_q;
    state_t state_d, state_q;
    logic [ENVBITS-1:0] env_d, env_q;
    logic [BITDEPTH-1:0] sample_out_d, sample_out_q;

    logic [GW-1:0] env_ext;
    logic [GW-1:0] atk_step, dec_step, sus_target;
    logic [GW-1:0] atk_sum, dec_diff, rel_dec, rel_diff;
    logic          rel_instant;
`ifdef ADSR_EXP_RELEASE_EN
    logic [GW-1:0] rel_shifted;
`endif

    logic signed [BITDEPTH-1:0] s_signed;
    logic signed [8:0]          gain;
    logic signed [BITDEPTH+8:0] product;
    logic signed [BITDEPTH-1:0] scaled;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            tick_q       <= 1'b0;
            state_q      <= ST_IDLE;
            env_q        <= '0;
            sample_out_q <= MIDPOINT;
        end else begin
            sync1_q      <= sample_clock;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            tick_q       <= tick_d;
            state_q      <= state_d;
            env_q        <= env_d;
            sample_out_q <= sample_out_d;
        end
    end

    assign tick_d = sync2_q & ~sync3_q;

    always_comb begin
        env_ext    = {1'b0, env_q};
        atk_step   = GW'({attack_rate, {STEPSHIFT{1'b0}}});
        dec_step   = GW'({decay_rate, {STEPSHIFT{1'b0}}});
        sus_target = GW'({sustain_level, {(ENVBITS-8){1'b0}}});
        atk_sum    = env_ext + atk_step;
        dec_diff   = env_ext - dec_step;
`ifdef ADSR_EXP_RELEASE_EN
        rel_shifted = env_ext >> release_rate[3:0];
        rel_dec     = (rel_shifted == '0) ? GW'(1) : rel_shifted;
        rel_instant = (release_rate[3:0] == 4'd0);
`else
        rel_dec     = GW'({release_rate, {STEPSHIFT{1'b0}}});
        rel_instant = (release_rate == '0);
`endif
        rel_diff   = env_ext - rel_dec;
    end

    // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (tick_q) begin
            if (gate && (state_q == ST_IDLE || state_q == ST_RELEASE)) begin
                state_d = ST_ATTACK;
            end else if (!gate && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                                   state_q == ST_SUSTAIN)) begin
                state_d = ST_RELEASE;
            end

            // The step is taken in the state just selected by the gate rules.
            case (state_d)
                ST_ATTACK: begin
                    if (attack_rate == '0 || atk_sum >= FULL_SCALE) begin
                        env_d   = FULL_SCALE[ENVBITS-1:0];
                        state_d = ST_DECAY;
                    end else begin
                        env_d = atk_sum[ENVBITS-1:0];
                    end
                end
                ST_DECAY: begin
                    if (decay_rate == '0 || env_ext <= sus_target ||
                        dec_diff[GW-1] || dec_diff <= sus_target) begin
                        env_d   = sus_target[ENVBITS-1:0];
                        state_d = ST_SUSTAIN;
                    end else begin
                        env_d = dec_diff[ENVBITS-1:0];
                    end
                end
                ST_SUSTAIN: begin
                    env_d = sus_target[ENVBITS-1:0];
                end
                ST_RELEASE: begin
                    if (rel_instant || rel_diff[GW-1] || rel_diff == '0) begin
                        env_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        env_d = rel_diff[ENVBITS-1:0];
                    end
                end
                default: begin
                    env_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Offset binary to signed by MSB flip, scale by the top 8 envelope bits, flip back.
    always_comb begin
        s_signed     = {~sample_in[BITDEPTH-1], sample_in[BITDEPTH-2:0]};
        gain         = {1'b0, env_q[ENVBITS-1 -: 8]};
        product      = s_signed * gain;
        scaled       = BITDEPTH'(product >>> 8);
        sample_out_d = {~scaled[BITDEPTH-1], scaled[BITDEPTH-2:0]};
    end

    assign sample_out = sample_out_q;
    assign env_level  = env_q;
    assign env_state  = state_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed self-checking bench for adsr_envelope: reset, ADSR phases, scaling, retrigger, async reset.
`timescale 1ns/1ps

module tb_adsr_envelope;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_clock;
    logic        gate;
    logic [7:0]  attack_rate, decay_rate, sustain_level, release_rate;
    logic [11:0] sample_in;
    logic [11:0] sample_out;
    logic [15:0] env_level;
    logic [2:0]  env_state;

    int total = 0;
    int bad   = 0;

    adsr_envelope dut (
        .clk           (clk),
        .rst           (rst),
        .sample_clock  (sample_clock),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .sample_in     (sample_in),
        .sample_out    (sample_out),
        .env_level     (env_level),
        .env_state     (env_state)
    );

    always #125 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One sample_clock period of 16 clk per tick; env settles well inside the low half.
    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) sample_clock = 1'b1;
            repeat (8) @(negedge clk);
            sample_clock = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    logic [15:0] r_env;
    int          guard_cnt;

    initial begin
        rst           = 1'b1;
        sample_clock  = 1'b0;
        gate          = 1'b0;
        attack_rate   = 8'h10;
        decay_rate    = 8'h20;
        sustain_level = 8'h80;
`ifdef ADSR_EXP_RELEASE_EN
        release_rate  = 8'h04;
`else
        release_rate  = 8'h40;
`endif
        sample_in     = 12'hFFF;

        repeat (3) @(negedge clk);
        check("rst_env", 32'(env_level), 32'h0);
        check("rst_state", 32'(env_state), 32'h0);
        check("rst_out", 32'(sample_out), 32'h800);
        rst = 1'b0;

        do_ticks(10);
        check("idle_env", 32'(env_level), 32'h0);
        check("idle_state", 32'(env_state), 32'h0);
        check("idle_out", 32'(sample_out), 32'h800);

        // Attack at 0x100 per tick.
        gate = 1'b1;
        do_ticks(1);
        check("atk1_env", 32'(env_level), 32'h0100);
        check("atk1_state", 32'(env_state), 32'd1);
        do_ticks(2);
        check("atk3_env", 32'(env_level), 32'h0300);
        do_ticks(252);
        check("atk255_env", 32'(env_level), 32'hFF00);
        check("atk255_state", 32'(env_state), 32'd1);
        do_ticks(1);
        check("atk256_env", 32'(env_level), 32'hFFFF);
        check("atk256_state", 32'(env_state), 32'd2);
        check("scale_fff_ffff", 32'(sample_out), 32'hFF7);

        // Decay at 0x200 per tick toward 0x8000.
        do_ticks(63);
        check("dec63_env", 32'(env_level), 32'h81FF);
        check("dec63_state", 32'(env_state), 32'd2);
        do_ticks(1);
        check("dec64_env", 32'(env_level), 32'h8000);
        check("dec64_state", 32'(env_state), 32'd3);
        check("scale_fff_8000", 32'(sample_out), 32'hBFF);

        sustain_level = 8'h40;
        do_ticks(1);
        check("sus_track_env", 32'(env_level), 32'h4000);
        check("sus_track_state", 32'(env_state), 32'd3);
        sustain_level = 8'h80;
        do_ticks(1);
        check("sus_back_env", 32'(env_level), 32'h8000);

        // Release from 0x8000.
        gate = 1'b0;
        do_ticks(1);
        check("rel1_state", 32'(env_state), 32'd4);
`ifdef ADSR_EXP_RELEASE_EN
        check("rel1_env", 32'(env_level), 32'h7800);
        do_ticks(1);
        check("rel2_env", 32'(env_level), 32'h7080);
        guard_cnt = 0;
        while (env_state != 3'd0 && guard_cnt < 400) begin
            do_ticks(1);
            guard_cnt++;
        end
        check("rel_exp_reached_idle", 32'(guard_cnt < 400), 32'd1);
`else
        check("rel1_env", 32'(env_level), 32'h7C00);
        do_ticks(30);
        check("rel31_env", 32'(env_level), 32'h0400);
        check("rel31_state", 32'(env_state), 32'd4);
        do_ticks(1);
`endif
        check("rel_end_env", 32'(env_level), 32'h0);
        check("rel_end_state", 32'(env_state), 32'd0);
        check("scale_env0", 32'(sample_out), 32'h800);

        // Instant attack and decay (rate 0).
        attack_rate = 8'h00;
        decay_rate  = 8'h00;
        gate        = 1'b1;
        do_ticks(1);
        check("inst_atk_env", 32'(env_level), 32'hFFFF);
        check("inst_atk_state", 32'(env_state), 32'd2);
        sample_in = 12'h000;
        repeat (2) @(negedge clk);
        check("scale_000_ffff", 32'(sample_out), 32'h008);
        do_ticks(1);
        check("inst_dec_env", 32'(env_level), 32'h8000);
        check("inst_dec_state", 32'(env_state), 32'd3);
        sample_in = 12'hFFF;

        // Release partway, then retrigger.
        gate = 1'b0;
`ifdef ADSR_EXP_RELEASE_EN
        do_ticks(1);
        r_env = 16'h7800;
`else
        do_ticks(20);
        r_env = 16'h3000;
`endif
        check("rel_mid_env", 32'(env_level), 32'(r_env));
        check("rel_mid_state", 32'(env_state), 32'd4);
        attack_rate = 8'h10;
        gate        = 1'b1;
        do_ticks(1);
        check("retrig_env", 32'(env_level), 32'(r_env + 16'h0100));
        check("retrig_state", 32'(env_state), 32'd1);

        // Asynchronous reset between clk edges.
        @(negedge clk);
        #10 rst = 1'b1;
        #1;
        check("async_rst_env", 32'(env_level), 32'h0);
        check("async_rst_state", 32'(env_state), 32'h0);
        check("async_rst_out", 32'(sample_out), 32'h800);
        @(negedge clk) rst = 1'b0;
        do_ticks(1);
        check("post_rst_env", 32'(env_level), 32'h0100);
        check("post_rst_state", 32'(env_state), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
